// File: rtl/seg7_scan_ctrl.sv
// Seven-segment scan controller: double-buffered digit word, guarded digit slots, frame-aligned swap.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros using a mask computed at load.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2
) (
  input  logic                  CLK_100MHz,
  input  logic                  RST,
  input  logic                  i_ce,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DIGITS-1:0]     o_an,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic                  o_frame
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_LIT   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     disp_q, disp_d, pend_q, pend_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic              full_q, full_d;
  logic              ready_q, ready_d;
  logic              frame_q, frame_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              xfer, wrap, load;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] mask_q, mask_d;
`endif

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h3F;
      4'hB: decode = 7'h06;
      4'hC: decode = 7'h2F;
      4'hD: decode = 7'h23;
      default: decode = 7'h7F;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A zero is blanked while every digit above it is zero/blank with no dp at or above it.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [DW-1:0] d, input logic [DIGITS-1:0] p);
    logic       ok;
    logic [3:0] c;
    lz_mask = '0;
    ok      = 1'b1;
    for (int n = int'(DIGITS) - 1; n > 0; n--) begin
      c          = d[4*n +: 4];
      lz_mask[n] = ok & (c == 4'h0) & ~p[n];
      ok         = ok & ((c == 4'h0) | (c >= 4'hE)) & ~p[n];
    end
  endfunction
`endif

  // Next-state, buffer and output computation.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    full_d    = full_q;
    wrap      = 1'b0;
    load      = 1'b0;
    xfer      = i_valid & ready_q;

    if (i_ce) begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            disp_d    = i_data;
            disp_dp_d = i_dp;
            load      = 1'b1;
            state_d   = S_GUARD;
            slot_d    = '0;
            idx_d     = '0;
          end else if (full_q) begin
            disp_d    = pend_q;
            disp_dp_d = pend_dp_q;
            full_d    = 1'b0;
            load      = 1'b1;
            state_d   = S_GUARD;
            slot_d    = '0;
            idx_d     = '0;
          end
        end
        S_GUARD: begin
          if (slot_q == CW'(GUARD - 1)) state_d = S_LIT;
          slot_d = CW'(slot_q + 1'b1);
        end
        S_LIT: begin
          if (slot_q == CW'(REFRESH_DIV - 1)) begin
            slot_d  = '0;
            state_d = S_GUARD;
            if (idx_q == IW'(DIGITS - 1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = IW'(idx_q + 1'b1);
            end
          end else begin
            slot_d = CW'(slot_q + 1'b1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Pending word is promoted only at a frame wrap.
    if (wrap && full_q) begin
      disp_d    = pend_q;
      disp_dp_d = pend_dp_q;
      full_d    = 1'b0;
      load      = 1'b1;
    end
    if (xfer && !(i_ce && state_q == S_IDLE)) begin
      pend_d    = i_data;
      pend_dp_d = i_dp;
      full_d    = 1'b1;
    end

`ifdef LEADING_ZERO_BLANK_EN
    mask_d = load ? lz_mask(disp_d, disp_dp_d) : mask_q;
`endif

    ready_d = ~full_d;
    frame_d = wrap;
    an_d    = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (state_d == S_LIT) begin
      an_d[idx_d] = 1'b0;
      seg_d       = decode(disp_d[{idx_d, 2'b00} +: 4]);
      dp_d        = ~disp_dp_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
      if (mask_d[idx_d]) seg_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      idx_q     <= '0;
      disp_q    <= '1;
      disp_dp_q <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      full_q    <= 1'b0;
      ready_q   <= 1'b1;
      frame_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      full_q    <= full_d;
      ready_q   <= ready_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
`ifdef LEADING_ZERO_BLANK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign o_ready = ready_q;
  assign o_frame = frame_q;
  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected lit slots, a monitor pops them.
module tb_seg7_scan_ctrl;

  logic        CLK_100MHz = 1'b0;
  logic        RST;
  logic        i_ce;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  int   exp_period = 16;
  logic tog_en = 1'b0;
  logic ce_s = 1'b1;

  seg7_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
    .CLK_100MHz(CLK_100MHz), .RST(RST), .i_ce(i_ce), .i_data(i_data), .i_dp(i_dp),
    .i_valid(i_valid), .o_ready(o_ready), .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp),
    .o_frame(o_frame)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    exp_q.push_back({an, seg, dp});
  endtask

  // ce toggler runs after the stimulus drive point so the two never collide
  initial forever begin
    @(posedge CLK_100MHz);
    #2;
    if (tog_en) i_ce = ~i_ce;
  end

  always @(posedge CLK_100MHz) ce_s = i_ce;

  // Monitor: pops one expected entry whenever a new digit slot lights up
  logic [3:0]  prev_an  = 4'hF;
  logic        prev_fr  = 1'b0;
  logic [11:0] prev_out = 12'hFFF;
  int          cyc = 0, last_cyc = 0;
  logic        last_ok = 1'b0;
  logic [11:0] e;
  always @(negedge CLK_100MHz) begin
    cyc++;
    if (RST) begin
      last_ok = 1'b0;
    end else begin
      if (o_an != 4'hF && prev_an == 4'hF) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_lit: got an=%h required no lit digit", o_an);
        end else begin
          e = exp_q.pop_front();
          check("slot{an,seg,dp}", 32'({o_an, o_seg, o_dp}), 32'(e));
        end
      end
      if (o_frame) begin
        check("frame_width", 32'(prev_fr), 32'd0);
        if (last_ok) check("frame_period", 32'(cyc - last_cyc), 32'(exp_period));
        last_cyc = cyc;
        last_ok  = 1'b1;
      end
      if (tog_en && !ce_s) check("frozen_on_ce0", 32'({o_an, o_seg, o_dp}), 32'(prev_out));
    end
    prev_an  = o_an;
    prev_fr  = o_frame;
    prev_out = {o_an, o_seg, o_dp};
  end

  task automatic send(input logic [15:0] d, input logic [3:0] p);
    logic got = 1'b0;
    i_data  = d;
    i_dp    = p;
    i_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_100MHz);
      if (o_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("send_ready", 32'(got), 32'd1);
    if (got) begin
      @(posedge CLK_100MHz);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_100MHz);
      if (o_frame) break;
    end
    check(name, 32'(o_frame), 32'd1);
  endtask

  task automatic do_reset(input int leftover);
    #2;
    check("queue_at_reset", 32'(exp_q.size()), 32'(leftover));
    exp_q.delete();
    RST     = 1'b1;
    tog_en  = 1'b0;
    i_ce    = 1'b1;
    i_valid = 1'b0;
    #1;
    check("rst_an", 32'(o_an), 32'hF);
    check("rst_seg", 32'(o_seg), 32'h7F);
    check("rst_dp", 32'(o_dp), 32'd1);
    check("rst_ready", 32'(o_ready), 32'd1);
    repeat (2) @(posedge CLK_100MHz);
    #1;
    RST = 1'b0;
    repeat (20) @(posedge CLK_100MHz);
    #1;
    check("idle_an", 32'(o_an), 32'hF);
    check("idle_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic bad;
    logic found;
    RST = 1'b1; i_ce = 1'b1; i_valid = 1'b0; i_data = '0; i_dp = '0;
    repeat (3) @(posedge CLK_100MHz);
    #1;
    check("reset_an", 32'(o_an), 32'hF);
    check("reset_seg", 32'(o_seg), 32'h7F);
    check("reset_dp", 32'(o_dp), 32'd1);
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_frame", 32'(o_frame), 32'd0);
    RST = 1'b0;
    repeat (50) @(posedge CLK_100MHz);
    #1;
    check("idle50_an", 32'(o_an), 32'hF);

    // 1234: two frames expected before the mid-frame update takes effect
    for (int f = 0; f < 2; f++) begin
      push(4'b1110, 7'h19, 1'b1);
      push(4'b1101, 7'h30, 1'b1);
      push(4'b1011, 7'h24, 1'b1);
      push(4'b0111, 7'h79, 1'b1);
    end
    send(16'h1234, 4'h0);
    check("ready_after_idle_load", 32'(o_ready), 32'd1);
    check("guard_after_load", 32'(o_an), 32'hF);
    @(posedge CLK_100MHz);
    #1;
    check("first_lit_an", 32'(o_an), 32'hE);
    check("first_lit_seg", 32'(o_seg), 32'h19);

    wait_frame("frame1_wait");
    repeat (5) @(posedge CLK_100MHz);
    #1;
    push(4'b1110, 7'h00, 1'b1);
    push(4'b1101, 7'h78, 1'b1);
    push(4'b1011, 7'h02, 1'b1);
    push(4'b0111, 7'h12, 1'b1);
    send(16'h5678, 4'h0);
    check("ready_drop", 32'(o_ready), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_100MHz);
      if (o_frame) break;
      if (o_ready) bad = 1'b1;
    end
    check("ready_low_until_frame", 32'(bad), 32'd0);
    check("frame2_wait", 32'(o_frame), 32'd1);
    check("ready_after_swap", 32'(o_ready), 32'd1);

    // reset while digit 2 of the 5678 frame is lit; digit 3 stays queued
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_100MHz);
      if (o_an == 4'hB) begin
        found = 1'b1;
        break;
      end
    end
    check("digit2_lit_wait", 32'(found), 32'd1);
    do_reset(1);

    // ce toggling: 9ABC with dp on digits 0 and 2, slot doubles to 8 clocks
    exp_period = 32;
    for (int f = 0; f < 2; f++) begin
      push(4'b1110, 7'h2F, 1'b0);
      push(4'b1101, 7'h06, 1'b1);
      push(4'b1011, 7'h3F, 1'b0);
      push(4'b0111, 7'h10, 1'b1);
    end
    tog_en = 1'b1;
    send(16'h9ABC, 4'b0101);
    wait_frame("tog_frame1_wait");
    wait_frame("tog_frame2_wait");
    do_reset(0);

    // leading-zero word
    exp_period = 16;
    push(4'b1110, 7'h40, 1'b1);
    push(4'b1101, 7'h78, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    push(4'b1011, 7'h7F, 1'b1);
    push(4'b0111, 7'h7F, 1'b1);
`else
    push(4'b1011, 7'h40, 1'b1);
    push(4'b0111, 7'h40, 1'b1);
`endif
    send(16'h0070, 4'h0);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_100MHz);
      if (exp_q.size() == 0) break;
    end
    do_reset(0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
